instr_stream_feeder: RTL and testbench

Parametrised instruction-stream feeder for the pipelined MIPS CPU bench and bring-up harness. Holds a loadable program of `DEPTH` words and presents them on the CPU's `IM_RD` input, either sequentially or indexed by the CPU's fetch address `PCF`. Supports issue count, stall, completion signalling and configurable index wrap. Replaces hand-stepped per-cycle instruction driving with a synthesizable, clock-accurate source.

---
 rtl/feeder_pkg.sv | 12 +
 rtl/instr_stream_feeder_if.sv | 33 +++
 rtl/feeder_prog_mem.sv | 27 ++
 rtl/instr_stream_feeder.sv | 143 ++++++++++++++
 tb/tb_instr_stream_feeder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/feeder_pkg.sv
// Shared types and constants for the instruction-stream feeder.
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_stream_feeder_if.sv
// Program-load, run-control and instruction-output bundle of the feeder.
// master = harness/driver side, slave = feeder side.
interface instr_stream_feeder_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int COUNT_W = 8
);

  logic               LOAD_EN;
  logic [ADDR_W-1:0]  LOAD_ADDR;
  logic [DATA_W-1:0]  LOAD_DATA;
  logic               START;
  logic [COUNT_W-1:0] COUNT;
  logic               MODE;
  logic               STALL;
  logic [DATA_W-1:0]  PCF;
  logic [DATA_W-1:0]  IM_RD;
  logic               VALID;
  logic               BUSY;
  logic               DONE;
  logic [COUNT_W-1:0] ISSUED;

  modport master (
    output LOAD_EN, LOAD_ADDR, LOAD_DATA, START, COUNT, MODE, STALL, PCF,
    input  IM_RD, VALID, BUSY, DONE, ISSUED
  );

  modport slave (
    input  LOAD_EN, LOAD_ADDR, LOAD_DATA, START, COUNT, MODE, STALL, PCF,
    output IM_RD, VALID, BUSY, DONE, ISSUED
  );

endinterface

// File: rtl/feeder_prog_mem.sv
// Program store: DEPTH x DATA_W register array, synchronous write, asynchronous read.
// Deliberately unreset so a loaded program survives a run abort.
module feeder_prog_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Combinational read lets a same-edge write/issue pair see the old word.
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/instr_stream_feeder.sv
// Instruction-stream feeder: presents a loaded program on IM_RD, sequentially or by PCF.
// Build option: define FEEDER_WRAP_EN to let the sequential index wrap modulo DEPTH.
module instr_stream_feeder
  import feeder_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 16,
  parameter int                ADDR_W  = $clog2(DEPTH),
  parameter int                COUNT_W = 8,
  parameter logic [DATA_W-1:0] PC_BASE = '0
) (
  input logic                 CLK,
  input logic                 RST,
  instr_stream_feeder_if.slave bus
);

  localparam logic [DATA_W-1:0] DEPTH_D = DATA_W'(DEPTH);
  localparam logic [DATA_W-1:0] NOP_D   = DATA_W'(NOP_WORD);

  state_t             state_reg;
  logic [DATA_W-1:0]  im_rd_reg;
  logic               valid_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [COUNT_W-1:0] issued_reg;
  logic [COUNT_W-1:0] count_reg;
  logic [COUNT_W-1:0] seq_idx_reg;
  logic               mode_reg;

  logic [DATA_W-1:0]  pc_off;
  logic [DATA_W-1:0]  pc_idx;
  logic               use_pc;
  logic [COUNT_W-1:0] seq_idx;
  logic               seq_in_range;
  logic               in_range;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  next_word;
  logic               mem_we;

  assign mem_we = bus.LOAD_EN && (state_reg == IDLE);

  feeder_prog_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_mem (
    .CLK     (CLK),
    .we      (mem_we),
    .wr_addr (bus.LOAD_ADDR),
    .wr_data (bus.LOAD_DATA),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef FEEDER_WRAP_EN
  assign seq_in_range = 1'b1;
`else
  localparam logic [COUNT_W:0] DEPTH_C = (COUNT_W + 1)'(DEPTH);
  assign seq_in_range = ({1'b0, seq_idx} < DEPTH_C);
`endif

  // The word for the coming issue edge. On the START edge the run settings are
  // still on the bus, so MODE and a zero sequential index are taken from there.
  always_comb begin
    pc_off    = bus.PCF - PC_BASE;
    pc_idx    = pc_off >> 2;
    use_pc    = (state_reg == IDLE) ? bus.MODE : mode_reg;
    seq_idx   = (state_reg == IDLE) ? '0 : seq_idx_reg;
    rd_addr   = seq_idx[ADDR_W-1:0];
    in_range  = seq_in_range;
    if (use_pc) begin
      rd_addr  = pc_idx[ADDR_W-1:0];
      in_range = (bus.PCF >= PC_BASE) && (pc_idx < DEPTH_D);
    end
    next_word = in_range ? rd_data : NOP_D;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      im_rd_reg   <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      issued_reg  <= '0;
      count_reg   <= '0;
      seq_idx_reg <= '0;
      mode_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.START) begin
            count_reg <= bus.COUNT;
            mode_reg  <= bus.MODE;
            if (bus.COUNT == '0) begin
              issued_reg  <= '0;
              seq_idx_reg <= '0;
              done_reg    <= 1'b1;
              state_reg   <= FIN;
            end else begin
              im_rd_reg   <= next_word;
              valid_reg   <= 1'b1;
              busy_reg    <= 1'b1;
              issued_reg  <= COUNT_W'(1);
              seq_idx_reg <= COUNT_W'(1);
              state_reg   <= RUN;
            end
          end
        end
        RUN: begin
          if (!bus.STALL) begin
            if (issued_reg == count_reg) begin
              im_rd_reg <= NOP_D;
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= FIN;
            end else begin
              im_rd_reg   <= next_word;
              issued_reg  <= issued_reg + COUNT_W'(1);
              seq_idx_reg <= seq_idx_reg + COUNT_W'(1);
            end
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.IM_RD  = im_rd_reg;
  assign bus.VALID  = valid_reg;
  assign bus.BUSY   = busy_reg;
  assign bus.DONE   = done_reg;
  assign bus.ISSUED = issued_reg;

endmodule

// File: tb/tb_instr_stream_feeder.sv
// Scoreboard bench for instr_stream_feeder: a DEPTH=16 PC-mapped instance and a DEPTH=4 overrun instance.
module tb_instr_stream_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_stream_feeder_if #(.DATA_W(32), .ADDR_W(4), .COUNT_W(8)) a_if ();
  instr_stream_feeder_if #(.DATA_W(32), .ADDR_W(2), .COUNT_W(8)) b_if ();

  instr_stream_feeder #(
    .DATA_W(32), .DEPTH(16), .ADDR_W(4), .COUNT_W(8), .PC_BASE(32'h0040_0000)
  ) dut_a (
    .CLK (clk),
    .RST (rst_n),
    .bus (a_if.slave)
  );

  instr_stream_feeder #(
    .DATA_W(32), .DEPTH(4), .ADDR_W(2), .COUNT_W(8), .PC_BASE(32'h0000_0000)
  ) dut_b (
    .CLK (clk),
    .RST (rst_n),
    .bus (b_if.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model_a [16];
  logic [31:0] model_b [4];
  logic [31:0] exp_qa [$];
  logic [31:0] exp_qb [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] seq_word_a(input int i);
`ifdef FEEDER_WRAP_EN
    return model_a[i % 16];
`else
    return (i < 16) ? model_a[i] : 32'h0;
`endif
  endfunction

  function automatic logic [31:0] seq_word_b(input int i);
`ifdef FEEDER_WRAP_EN
    return model_b[i % 4];
`else
    return (i < 4) ? model_b[i] : 32'h0;
`endif
  endfunction

  function automatic logic [31:0] pc_word_a(input logic [31:0] pcf);
    logic [31:0] off;
    logic [31:0] idx;
    off = pcf - 32'h0040_0000;
    idx = off >> 2;
    if (pcf < 32'h0040_0000 || idx >= 32'd16) return 32'h0;
    return model_a[idx[3:0]];
  endfunction

  // Instance A monitor: a new issue is VALID rising or ISSUED moving; otherwise the word must hold.
  logic        prev_valid_a = 1'b0;
  logic [7:0]  prev_issued_a = 8'd0;
  logic [31:0] last_a = 32'h0;
  logic [31:0] exp_wa;
  always @(negedge clk) begin
    if (a_if.VALID) begin
      if (!prev_valid_a || a_if.ISSUED != prev_issued_a) begin
        if (exp_qa.size() == 0) begin
          check_val("a_unexpected_issue", 32'd1, 32'd0);
        end else begin
          exp_wa = exp_qa.pop_front();
          $display("A issue #%0d word=%h exp=%h", a_if.ISSUED, a_if.IM_RD, exp_wa);
          check_val("a_issue_word", a_if.IM_RD, exp_wa);
          last_a = exp_wa;
        end
      end else begin
        check_val("a_stall_hold", a_if.IM_RD, last_a);
      end
    end
    prev_valid_a  = a_if.VALID;
    prev_issued_a = a_if.ISSUED;
  end

  logic [31:0] exp_wb;
  always @(negedge clk) begin
    if (b_if.VALID) begin
      if (exp_qb.size() == 0) begin
        check_val("b_unexpected_issue", 32'd1, 32'd0);
      end else begin
        exp_wb = exp_qb.pop_front();
        $display("B issue #%0d word=%h exp=%h", b_if.ISSUED, b_if.IM_RD, exp_wb);
        check_val("b_issue_word", b_if.IM_RD, exp_wb);
      end
    end
  end

  task automatic load_a(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    a_if.LOAD_EN = 1'b1;
    a_if.LOAD_ADDR = addr;
    a_if.LOAD_DATA = data;
    @(posedge clk);
    #1;
    a_if.LOAD_EN = 1'b0;
    model_a[addr] = data;
  endtask

  // load_mode: 0 none, 1 write on the START edge, 2 write attempt during RUN (must be ignored).
  task automatic run_a(input int count, input bit mode, input logic [31:0] pcf, input int stall_len,
                       input int load_mode, input logic [3:0] la, input logic [31:0] ld);
    int vcnt;
    int bcnt;
    int dcyc;
    int exp_busy;
    vcnt = 0;
    bcnt = 0;
    dcyc = 0;
    for (int i = 0; i < count; i++) exp_qa.push_back(mode ? pc_word_a(pcf) : seq_word_a(i));
    @(negedge clk);
    a_if.START = 1'b1;
    a_if.COUNT = 8'(count);
    a_if.MODE  = mode;
    a_if.PCF   = pcf;
    if (load_mode == 1) begin
      a_if.LOAD_EN   = 1'b1;
      a_if.LOAD_ADDR = la;
      a_if.LOAD_DATA = ld;
    end
    @(posedge clk);
    #1;
    a_if.START   = 1'b0;
    a_if.LOAD_EN = 1'b0;
    if (load_mode == 1) model_a[la] = ld;
    for (int c = 1; c <= 300 && dcyc == 0; c++) begin
      @(negedge clk);
      if (a_if.VALID) vcnt++;
      if (a_if.BUSY) bcnt++;
      if (a_if.DONE) dcyc = c;
      a_if.STALL     = (c <= stall_len);
      a_if.LOAD_EN   = (load_mode == 2 && c == 1);
      a_if.LOAD_ADDR = la;
      a_if.LOAD_DATA = ld;
    end
    a_if.STALL   = 1'b0;
    a_if.LOAD_EN = 1'b0;
    exp_busy = (count == 0) ? 0 : count + stall_len;
    check_val("a_done_cycle", dcyc, (count == 0) ? 1 : count + stall_len + 1);
    check_val("a_valid_cycles", vcnt, exp_busy);
    check_val("a_busy_cycles", bcnt, exp_busy);
    @(negedge clk);
    check_val("a_done_pulse_width", a_if.DONE, 1'b0);
    check_val("a_issued_final", a_if.ISSUED, 8'(count));
    check_val("a_im_rd_idle_nop", a_if.IM_RD, 32'h0);
    check_val("a_queue_drained", exp_qa.size(), 0);
    $display("A run count=%0d mode=%0d pcf=%h stall=%0d done_cycle=%0d", count, mode, pcf, stall_len, dcyc);
  endtask

  initial begin
    int dcyc_b;
    a_if.LOAD_EN = 0; a_if.LOAD_ADDR = 0; a_if.LOAD_DATA = 0; a_if.START = 0;
    a_if.COUNT = 0; a_if.MODE = 0; a_if.STALL = 0; a_if.PCF = 0;
    b_if.LOAD_EN = 0; b_if.LOAD_ADDR = 0; b_if.LOAD_DATA = 0; b_if.START = 0;
    b_if.COUNT = 0; b_if.MODE = 0; b_if.STALL = 0; b_if.PCF = 0;

    repeat (3) @(negedge clk);
    check_val("rst_im_rd", a_if.IM_RD, 32'h0);
    check_val("rst_valid", a_if.VALID, 1'b0);
    check_val("rst_busy", a_if.BUSY, 1'b0);
    check_val("rst_done", a_if.DONE, 1'b0);
    check_val("rst_issued", a_if.ISSUED, 8'd0);
    check_val("rst_b_valid", b_if.VALID, 1'b0);
    rst_n = 1'b1;

    load_a(4'd0, 32'h2001_0005);
    load_a(4'd1, 32'h2002_0003);
    load_a(4'd2, 32'h0022_1820);
    for (int i = 3; i < 16; i++) load_a(4'(i), 32'hA000_0000 | 32'(i));

    run_a(3, 1'b0, 32'h0, 0, 0, 4'd0, 32'h0);
    run_a(3, 1'b0, 32'h0, 2, 0, 4'd0, 32'h0);
    run_a(2, 1'b1, 32'h0040_0008, 0, 0, 4'd0, 32'h0);
    run_a(1, 1'b1, 32'h0040_0040, 0, 0, 4'd0, 32'h0);
    run_a(1, 1'b1, 32'h003F_FFFC, 0, 0, 4'd0, 32'h0);
    run_a(1, 1'b1, 32'h0040_003C, 0, 0, 4'd0, 32'h0);
    run_a(18, 1'b0, 32'h0, 0, 0, 4'd0, 32'h0);
    run_a(0, 1'b0, 32'h0, 0, 0, 4'd0, 32'h0);
    run_a(3, 1'b0, 32'h0, 0, 2, 4'd1, 32'hDEAD_BEEF);
    run_a(2, 1'b0, 32'h0, 0, 0, 4'd0, 32'h0);
    run_a(1, 1'b0, 32'h0, 0, 1, 4'd0, 32'h1234_5678);
    run_a(1, 1'b0, 32'h0, 0, 0, 4'd0, 32'h0);

    // Abort a run after two issues; only those two words are expected.
    exp_qa.push_back(model_a[0]);
    exp_qa.push_back(model_a[1]);
    @(negedge clk);
    a_if.START = 1'b1; a_if.COUNT = 8'd3; a_if.MODE = 1'b0;
    @(posedge clk);
    #1;
    a_if.START = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_im_rd", a_if.IM_RD, 32'h0);
    check_val("midrst_valid", a_if.VALID, 1'b0);
    check_val("midrst_busy", a_if.BUSY, 1'b0);
    check_val("midrst_issued", a_if.ISSUED, 8'd0);
    check_val("midrst_two_issued", exp_qa.size(), 0);
    $display("A reset asserted mid-run");
    @(negedge clk);
    rst_n = 1'b1;
    run_a(3, 1'b0, 32'h0, 0, 0, 4'd0, 32'h0);

    // DEPTH=4 instance: six sequential issues past the end of the program.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_if.LOAD_EN = 1'b1;
      b_if.LOAD_ADDR = 2'(i);
      b_if.LOAD_DATA = 32'hB000_0010 + 32'(i);
      @(posedge clk);
      #1;
      b_if.LOAD_EN = 1'b0;
      model_b[i] = 32'hB000_0010 + 32'(i);
    end
    for (int i = 0; i < 6; i++) exp_qb.push_back(seq_word_b(i));
    @(negedge clk);
    b_if.START = 1'b1; b_if.COUNT = 8'd6; b_if.MODE = 1'b0;
    @(posedge clk);
    #1;
    b_if.START = 1'b0;
    dcyc_b = 0;
    for (int c = 1; c <= 100 && dcyc_b == 0; c++) begin
      @(negedge clk);
      if (b_if.DONE) dcyc_b = c;
    end
    check_val("b_done_cycle", dcyc_b, 7);
    check_val("b_issued_final", b_if.ISSUED, 8'd6);
    check_val("b_queue_drained", exp_qb.size(), 0);
    $display("B run count=6 done_cycle=%0d", dcyc_b);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
